// File: rtl/cmp_seq_n.sv
// ============================================================================
// Module   : cmp_seq_n
// Purpose  : Multi-cycle signed/unsigned magnitude comparator, MSB chunk first,
//            early exit on the first differing chunk. Optional min/max outputs
//            are enabled by defining CMP_MINMAX_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_seq_n #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_mode,
  output logic         o_valid,
  input  logic         o_ready,
  output logic         lt,
  output logic         eq,
  output logic         gt
`ifdef CMP_MINMAX_EN
  ,
  output logic [N-1:0] min_out,
  output logic [N-1:0] max_out
`endif
);

  localparam int                c_K    = N / CHUNK;
  localparam int                c_IW   = (c_K > 1) ? $clog2(c_K) : 1;
  localparam logic [c_IW-1:0]   c_LAST = c_IW'(c_K - 1);
  localparam logic [CHUNK-1:0]  c_MSB  = CHUNK'(1) << (CHUNK - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SCAN = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic            sgn_q, sgn_d;
  logic [c_IW-1:0] idx_q, idx_d;
  logic            lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
`ifdef CMP_MINMAX_EN
  logic [N-1:0]    min_q, min_d, max_q, max_d;
`endif

  logic [CHUNK-1:0] w_ca, w_cb, w_bias;
  logic             w_lt, w_gt;

  // Flipping the sign bit of the top chunk maps two's complement order onto unsigned order.
  assign w_bias = (sgn_q && (idx_q == c_LAST)) ? c_MSB : '0;
  assign w_ca   = a_q[CHUNK*int'(idx_q) +: CHUNK] ^ w_bias;
  assign w_cb   = b_q[CHUNK*int'(idx_q) +: CHUNK] ^ w_bias;
  assign w_lt   = (w_ca < w_cb);
  assign w_gt   = (w_ca > w_cb);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
`ifdef CMP_MINMAX_EN
    min_d   = min_q;
    max_d   = max_q;
`endif
    case (state_q)
      c_IDLE: begin
        if (i_valid) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = signed_mode;
          idx_d   = c_LAST;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = c_SCAN;
        end
      end
      c_SCAN: begin
        if (w_lt || w_gt || (idx_q == '0)) begin
          lt_d    = w_lt;
          gt_d    = w_gt;
          eq_d    = !(w_lt || w_gt);
          state_d = c_DONE;
`ifdef CMP_MINMAX_EN
          // Equal operands fall through to min=A, max=B, which are identical.
          min_d   = w_gt ? b_q : a_q;
          max_d   = w_gt ? a_q : b_q;
`endif
        end else begin
          idx_d = idx_q - c_IW'(1);
        end
      end
      c_DONE: begin
        if (o_ready) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
`ifdef CMP_MINMAX_EN
      min_q   <= '0;
      max_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
`ifdef CMP_MINMAX_EN
      min_q   <= min_d;
      max_q   <= max_d;
`endif
    end
  end

  assign i_ready = (state_q == c_IDLE);
  assign o_valid = (state_q == c_DONE);
  assign lt      = lt_q;
  assign eq      = eq_q;
  assign gt      = gt_q;
`ifdef CMP_MINMAX_EN
  assign min_out = min_q;
  assign max_out = max_q;
`endif

endmodule

`default_nettype wire
